posit_div_arb: RTL and testbench

Round-robin arbiter and sequencer that shares one combinational `posit_div` instance among `NREQ` requesters in the CVXIF posit arithmetic unit. It registers the granted operands and holds them stable for `DIV_CYCLES` cycles, so the divider can be closed as a multicycle path. It then captures the quotient and flags into a response buffer, which is drained through a valid/ready handshake tagged with the requester index.

---
 rtl/posit_div_arb.sv | 267 ++++++++++++++++++++++++++
 tb/tb_posit_div_arb.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/posit_div_arb.sv
// posit_div_arb: round-robin arbiter/sequencer that time-shares one
// combinational posit divider among NREQ requesters. Operands are registered
// and held for DIV_CYCLES cycles so the divider can be closed as a multicycle
// path; the result is parked in a response buffer drained via valid/ready.

// Combinational posit divider (round to nearest even, saturating to
// minpos/maxpos; NaR on x/0 or NaR input).
module posit_div #(
    parameter int N  = 16,
    parameter int ES = 3
) (
    input  logic [N-1:0] in1,
    input  logic [N-1:0] in2,
    input  logic         start,
    output logic [N-1:0] out,
    output logic         inf,
    output logic         zero
);
    localparam int RW  = N - 1;                  // body width after sign
    localparam int FW  = N - ES - 3;             // max fraction bits
    localparam int SW  = $clog2(N) + ES + 2;     // decoded scale width
    localparam int SHW = $clog2(N) + 1;          // regime run/shift width
    localparam int QF  = FW + 4;                 // quotient fraction bits
    localparam int QW  = QF + 1;
    localparam int MW  = FW + 1;                 // mantissa incl. hidden bit
    localparam int DW  = MW + QF;
    localparam int L   = 2 + ES + QF + N - 3;    // regime build window

    typedef struct packed {
        logic [SW-1:0] sc;
        logic [FW-1:0] fr;
    } dec_t;

    // Magnitude decode: regime run length gives k, then exponent and fraction.
    function automatic dec_t dec(input logic [N-1:0] p);
        logic [RW-1:0]  rem;
        logic [SHW-1:0] run;
        logic           done;
        logic [SW-1:0]  k;
        logic [N-4:0]   ef;
        dec_t           d;
        rem  = RW'(p[N-1] ? -p : p);
        run  = '0;
        done = 1'b0;
        for (int i = N - 2; i >= 0; i--) begin
            if (!done && rem[i] == rem[N-2]) run = run + 1'b1;
            else                             done = 1'b1;
        end
        k    = rem[N-2] ? SW'(run) - SW'(1) : SW'(0) - SW'(run);
        ef   = rem[N-4:0] << (run - 1'b1);
        d.sc = (k << ES) + SW'(ef[N-4 -: ES]);
        d.fr = ef[FW-1:0];
        return d;
    endfunction

    dec_t               da, db;
    logic [DW-1:0]      num, den;
    logic [QW-1:0]      q;
    logic [MW-1:0]      r;
    logic [QF-1:0]      fq;
    logic signed [SW:0] scd, k;
    logic [SHW-1:0]     sh;
    logic signed [L-1:0] w, ws;
    logic [RW-1:0]      body, mag;
    logic               guard, stk, rup, nar;
    logic [N-1:0]       res;

    assign da  = dec(in1);
    assign db  = dec(in2);
    assign num = {1'b1, da.fr, {QF{1'b0}}};
    assign den = DW'({1'b1, db.fr});
    assign q   = QW'(num / den);
    assign r   = MW'(num % den);
    assign nar = (in1 == {1'b1, {RW{1'b0}}}) || (in2 == {1'b1, {RW{1'b0}}}) || (in2 == '0);

    // Normalise the quotient, rebuild regime/exponent/fraction and round.
    always_comb begin
        fq    = q[QF] ? q[QF-1:0] : {q[QF-2:0], 1'b0};
        scd   = {da.sc[SW-1], da.sc} - {db.sc[SW-1], db.sc} - {{SW{1'b0}}, ~q[QF]};
        k     = scd >>> ES;
        sh    = (k >= 0) ? SHW'(k) : SHW'(-k - 1);
        w     = (k >= 0) ? {2'b10, scd[ES-1:0], fq, {(N-3){1'b0}}}
                         : {2'b01, scd[ES-1:0], fq, {(N-3){1'b0}}};
        ws    = w >>> sh;
        body  = ws[L-1 -: RW];
        guard = ws[L-N];
        stk   = (|ws[L-N-1:0]) | (r != '0);
        rup   = guard & (stk | body[0]) & ~(&body);
        if (k >= N - 2)         mag = '1;
        else if (k < -(N - 2))  mag = RW'(1);
        else                    mag = body + RW'(rup);
        res   = (in1[N-1] ^ in2[N-1]) ? -{1'b0, mag} : {1'b0, mag};
    end

    // Special-value override; outputs are quiet when not started.
    always_comb begin
        out  = '0;
        inf  = 1'b0;
        zero = 1'b0;
        if (start) begin
            if (nar) begin
                out = {1'b1, {RW{1'b0}}};
                inf = 1'b1;
            end else if (in1 == '0) begin
                zero = 1'b1;
            end else begin
                out = res;
            end
        end
    end
endmodule

module posit_div_arb #(
    parameter int N          = 16,
    parameter int ES         = 3,
    parameter int NREQ       = 4,
    parameter int DIV_CYCLES = 2,
    parameter int IDW        = $clog2(NREQ)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [NREQ-1:0]   req_valid_i,
    output logic [NREQ-1:0]   req_ready_o,
    input  logic [NREQ*N-1:0] req_op_a_i,
    input  logic [NREQ*N-1:0] req_op_b_i,
    input  logic              flush_i,
    output logic              resp_valid_o,
    input  logic              resp_ready_i,
    output logic [IDW-1:0]    resp_id_o,
    output logic [N-1:0]      resp_data_o,
    output logic              resp_inf_o,
    output logic              resp_zero_o,
    output logic              busy_o
);
    localparam int CW = $clog2(DIV_CYCLES) + 1;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t         state_q, state_d;
    logic [N-1:0]   op_a_q, op_a_d, op_b_q, op_b_d, rdata_q, rdata_d;
    logic [IDW-1:0] id_q, id_d, ptr_q, ptr_d, rid_q, rid_d, gidx;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           rvalid_q, rvalid_d, rinf_q, rinf_d, rzero_q, rzero_d;
    logic           found, win, grant;
    logic [N-1:0]   div_out;
    logic           div_inf, div_zero;

    // Shared divider sees only the held operand registers.
    posit_div #(.N(N), .ES(ES)) u_div (
        .in1  (op_a_q),
        .in2  (op_b_q),
        .start(1'b1),
        .out  (div_out),
        .inf  (div_inf),
        .zero (div_zero)
    );

    // Accept window: idle, or draining a response this cycle; flush blocks it.
    assign win   = !flush_i && (state_q == IDLE || (state_q == RESP && resp_ready_i));
    assign grant = win && found;

    // Round-robin search of valid requests starting at ptr.
    always_comb begin
        int j;
        j     = 0;
        found = 1'b0;
        gidx  = '0;
        for (int i = 0; i < NREQ; i++) begin
            j = (int'(ptr_q) + i) % NREQ;
            if (!found && req_valid_i[j]) begin
                found = 1'b1;
                gidx  = IDW'(j);
            end
        end
    end

    // One-hot accept for the winner only.
    always_comb begin
        req_ready_o = '0;
        if (grant) req_ready_o[gidx] = 1'b1;
    end

    // Next-state: grant loads operands, EXEC counts down then captures.
    always_comb begin
        state_d  = state_q;
        op_a_d   = op_a_q;
        op_b_d   = op_b_q;
        id_d     = id_q;
        ptr_d    = ptr_q;
        cnt_d    = cnt_q;
        rvalid_d = rvalid_q;
        rdata_d  = rdata_q;
        rid_d    = rid_q;
        rinf_d   = rinf_q;
        rzero_d  = rzero_q;
        if (flush_i) begin
            state_d  = IDLE;
            rvalid_d = 1'b0;
        end else begin
            case (state_q)
                EXEC: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - 1'b1;
                    end else begin
                        rdata_d  = div_out;
                        rinf_d   = div_inf;
                        rzero_d  = div_zero;
                        rid_d    = id_q;
                        rvalid_d = 1'b1;
                        state_d  = RESP;
                    end
                end
                RESP: begin
                    if (resp_ready_i) begin
                        rvalid_d = 1'b0;
                        state_d  = IDLE;
                    end
                end
                default: ;
            endcase
            if (grant) begin
                op_a_d  = req_op_a_i[gidx*N +: N];
                op_b_d  = req_op_b_i[gidx*N +: N];
                id_d    = gidx;
                ptr_d   = (gidx == IDW'(NREQ - 1)) ? '0 : gidx + 1'b1;
                cnt_d   = CW'(DIV_CYCLES - 1);
                state_d = EXEC;
            end
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            op_a_q   <= '0;
            op_b_q   <= '0;
            id_q     <= '0;
            ptr_q    <= '0;
            cnt_q    <= '0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            rid_q    <= '0;
            rinf_q   <= 1'b0;
            rzero_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_a_q   <= op_a_d;
            op_b_q   <= op_b_d;
            id_q     <= id_d;
            ptr_q    <= ptr_d;
            cnt_q    <= cnt_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
            rid_q    <= rid_d;
            rinf_q   <= rinf_d;
            rzero_q  <= rzero_d;
        end
    end

    assign resp_valid_o = rvalid_q;
    assign resp_id_o    = rid_q;
    assign resp_data_o  = rdata_q;
    assign resp_inf_o   = rinf_q;
    assign resp_zero_o  = rzero_q;
    assign busy_o       = (state_q != IDLE);
endmodule

// File: tb/tb_posit_div_arb.sv
// Scoreboard bench for posit_div_arb: expected responses queued at grant,
// popped and compared at each response handshake.
module tb_posit_div_arb;
    localparam int N    = 16;
    localparam int NREQ = 4;

    logic              clk_i = 1'b0;
    logic              rst_ni;
    logic [NREQ-1:0]   req_valid_i, req_ready_o;
    logic [NREQ*N-1:0] req_op_a_i, req_op_b_i;
    logic              flush_i, resp_valid_o, resp_ready_i;
    logic [1:0]        resp_id_o;
    logic [N-1:0]      resp_data_o;
    logic              resp_inf_o, resp_zero_o, busy_o;

    posit_div_arb dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_op_a_i  (req_op_a_i),
        .req_op_b_i  (req_op_b_i),
        .flush_i     (flush_i),
        .resp_valid_o(resp_valid_o),
        .resp_ready_i(resp_ready_i),
        .resp_id_o   (resp_id_o),
        .resp_data_o (resp_data_o),
        .resp_inf_o  (resp_inf_o),
        .resp_zero_o (resp_zero_o),
        .busy_o      (busy_o)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    typedef struct packed {
        logic [1:0]  id;
        logic [15:0] data;
        logic        inf;
        logic        zero;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   nchk = 0, nfail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic wait_grant(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk_i);
            if (req_ready_o != '0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("grant_timeout", 0, 1);
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk_i);
            if (!busy_o) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("idle_timeout", 0, 1);
    endtask

    task automatic set_req(input int k, input logic [15:0] a, input logic [15:0] b);
        req_op_a_i[k*N +: N] = a;
        req_op_b_i[k*N +: N] = b;
        req_valid_i[k]       = 1'b1;
    endtask

    // Single request from requester k, with latency check (valid at grant+3).
    task automatic do_req(input int k, input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] ed, input logic ei, input logic ez);
        bit ok;
        @(posedge clk_i); #1;
        set_req(k, a, b);
        wait_grant(ok);
        chk("grant", 32'(req_ready_o), 32'(1 << k));
        if (ok) sb.push_back('{id: 2'(k), data: ed, inf: ei, zero: ez});
        @(posedge clk_i); #1;
        req_valid_i[k] = 1'b0;
        @(negedge clk_i); chk("lat1", 32'(resp_valid_o), 0);
        @(negedge clk_i); chk("lat2", 32'(resp_valid_o), 0);
        @(negedge clk_i); chk("lat3", 32'(resp_valid_o), 1);
    endtask

    // Response monitor: every handshake must match the head of the scoreboard.
    always @(negedge clk_i) begin
        if (rst_ni && !flush_i && resp_valid_o && resp_ready_i) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected", 1, 0);
            end else begin
                mon_e = sb.pop_front();
                chk("resp_id",   32'(resp_id_o),   32'(mon_e.id));
                chk("resp_data", 32'(resp_data_o), 32'(mon_e.data));
                chk("resp_inf",  32'(resp_inf_o),  32'(mon_e.inf));
                chk("resp_zero", 32'(resp_zero_o), 32'(mon_e.zero));
            end
        end
    end

    logic [15:0] fa [4] = '{16'h4400, 16'h4000, 16'h4000, 16'h0000};
    logic [15:0] fb [4] = '{16'h4400, 16'h4400, 16'hC000, 16'h4000};
    logic [15:0] fq [4] = '{16'h4000, 16'h3C00, 16'hC000, 16'h0000};
    logic        fz [4] = '{1'b0, 1'b0, 1'b0, 1'b1};

    initial begin
        bit ok;
        int last;
        rst_ni       = 1'b0;
        req_valid_i  = '0;
        req_op_a_i   = '0;
        req_op_b_i   = '0;
        flush_i      = 1'b0;
        resp_ready_i = 1'b1;
        last         = 0;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        chk("rst_busy",   32'(busy_o), 0);
        chk("rst_rvalid", 32'(resp_valid_o), 0);
        chk("rst_data",   32'(resp_data_o), 0);
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        @(negedge clk_i);
        chk("idle_ready", 32'(req_ready_o), 0);
        chk("idle_busy",  32'(busy_o), 0);

        // single op: 2/2 on requester 1
        do_req(1, 16'h4400, 16'h4400, 16'h4000, 1'b0, 1'b0);
        wait_idle();

        // special values, one per requester (leaves ptr at 0)
        do_req(0, 16'h4000, 16'h4400, 16'h3C00, 1'b0, 1'b0); wait_idle();
        do_req(1, 16'h4000, 16'h0000, 16'h8000, 1'b1, 1'b0); wait_idle();
        do_req(2, 16'h0000, 16'h4000, 16'h0000, 1'b0, 1'b1); wait_idle();
        do_req(3, 16'h4000, 16'hC000, 16'hC000, 1'b0, 1'b0); wait_idle();

        // round-robin fairness with all requesters valid
        @(posedge clk_i); #1;
        for (int k = 0; k < NREQ; k++) set_req(k, fa[k], fb[k]);
        for (int i = 0; i < 5; i++) begin
            wait_grant(ok);
            chk("rr_grant", 32'(req_ready_o), 32'(1 << (i % 4)));
            if (i > 0) chk("rr_gap", 32'(cyc - last), 3);
            last = cyc;
            if (ok) sb.push_back('{id: 2'(i % 4), data: fq[i % 4], inf: 1'b0, zero: fz[i % 4]});
        end
        @(posedge clk_i); #1;
        req_valid_i = '0;
        wait_idle();

        // back-pressure: response held, no grants while consumer stalls
        @(posedge clk_i); #1;
        resp_ready_i = 1'b0;
        do_req(3, 16'h4000, 16'h4400, 16'h3C00, 1'b0, 1'b0);
        @(posedge clk_i); #1;
        set_req(2, 16'h4000, 16'h0000);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_i);
            chk("bp_ready",  32'(req_ready_o), 0);
            chk("bp_valid",  32'(resp_valid_o), 1);
            chk("bp_data",   32'(resp_data_o), 32'h3C00);
            chk("bp_id",     32'(resp_id_o), 3);
        end
        @(posedge clk_i); #1;
        resp_ready_i = 1'b1;
        @(negedge clk_i);
        chk("bp_grant", 32'(req_ready_o), 32'h4);
        sb.push_back('{id: 2'd2, data: 16'h8000, inf: 1'b1, zero: 1'b0});
        @(posedge clk_i); #1;
        req_valid_i = '0;
        wait_idle();

        // flush during EXEC: no response, pointer kept (1 granted -> ptr 2)
        @(posedge clk_i); #1;
        set_req(1, 16'h4400, 16'h4400);
        wait_grant(ok);
        chk("fl_grant", 32'(req_ready_o), 32'h2);
        @(posedge clk_i); #1;
        req_valid_i = '0;
        flush_i     = 1'b1;
        @(negedge clk_i);
        chk("fl_noready", 32'(req_ready_o), 0);
        @(posedge clk_i); #1;
        flush_i = 1'b0;
        @(negedge clk_i);
        chk("fl_idle",   32'(busy_o), 0);
        chk("fl_rvalid", 32'(resp_valid_o), 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            chk("fl_noresp", 32'(resp_valid_o), 0);
        end
        @(posedge clk_i); #1;
        set_req(1, 16'h4400, 16'h4400);
        set_req(3, 16'h4400, 16'h4000);
        wait_grant(ok);
        chk("fl_ptr", 32'(req_ready_o), 32'h8);
        if (ok) sb.push_back('{id: 2'd3, data: 16'h4400, inf: 1'b0, zero: 1'b0});
        @(posedge clk_i); #1;
        req_valid_i = '0;
        wait_idle();

        // asynchronous reset mid-EXEC (2 granted -> ptr 3 before reset)
        @(posedge clk_i); #1;
        set_req(2, 16'h4400, 16'h4400);
        wait_grant(ok);
        chk("rs_grant", 32'(req_ready_o), 32'h4);
        @(posedge clk_i); #1;
        req_valid_i = '0;
        #2;
        rst_ni = 1'b0;
        #1;
        chk("rs_busy",   32'(busy_o), 0);
        chk("rs_rvalid", 32'(resp_valid_o), 0);
        chk("rs_data",   32'(resp_data_o), 0);
        chk("rs_id",     32'(resp_id_o), 0);
        chk("rs_flags",  32'({resp_inf_o, resp_zero_o}), 0);
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        set_req(1, 16'h4000, 16'h4400);
        set_req(3, 16'h4400, 16'h4000);
        wait_grant(ok);
        chk("rs_ptr", 32'(req_ready_o), 32'h2);
        if (ok) sb.push_back('{id: 2'd1, data: 16'h3C00, inf: 1'b0, zero: 1'b0});
        @(posedge clk_i); #1;
        req_valid_i = '0;
        wait_idle();

        repeat (3) @(negedge clk_i);
        chk("sb_drain", 32'(sb.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
        $finish;
    end
endmodule
